// File: rtl/warp_scheduler_if.sv
// Bus bundle between a warp_scheduler and the rest of its core.
//
// master : the scheduler (drives the core_state / active_warp / pc / done outputs)
// slave  : the core or testbench (drives launch, fetch, decode, LSU and next-PC inputs)
//
// Signals
//   start           launch level for the block
//   warp_enable     warps holding valid threads
//   fetcher_state   fetcher status, 3'b010 = FETCHED
//   decoded_ret     RET decoded for the active warp
//   lsu_state       2 bits per warp/thread, warp-major; 01/10 mean busy
//   thread_mask     valid threads of the active warp
//   next_pc         per-thread next PC of the active warp, lane 0 in the LSBs
//   core_state      IDLE0 FETCH1 DECODE2 REQUEST3 WAIT4 EXECUTE5 UPDATE6 DONE7
//   active_warp     warp owning the pipeline
//   current_pc      PC of the active warp
//   warp_done       per-warp RET seen
//   block_done      all enabled warps finished
//   divergence_err  sticky lane-divergence flag
interface warp_scheduler_if #(
    parameter int NUM_WARPS        = 4,
    parameter int THREADS_PER_WARP = 4,
    parameter int PC_WIDTH         = 8
);
    localparam int WW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

    logic                                   start;
    logic [NUM_WARPS-1:0]                   warp_enable;
    logic [2:0]                             fetcher_state;
    logic                                   decoded_ret;
    logic [NUM_WARPS*THREADS_PER_WARP*2-1:0] lsu_state;
    logic [THREADS_PER_WARP-1:0]            thread_mask;
    logic [THREADS_PER_WARP*PC_WIDTH-1:0]   next_pc;
    logic [2:0]                             core_state;
    logic [WW-1:0]                          active_warp;
    logic [PC_WIDTH-1:0]                    current_pc;
    logic [NUM_WARPS-1:0]                   warp_done;
    logic                                   block_done;
    logic                                   divergence_err;

    modport master (
        input  start, warp_enable, fetcher_state, decoded_ret, lsu_state, thread_mask, next_pc,
        output core_state, active_warp, current_pc, warp_done, block_done, divergence_err
    );

    modport slave (
        output start, warp_enable, fetcher_state, decoded_ret, lsu_state, thread_mask, next_pc,
        input  core_state, active_warp, current_pc, warp_done, block_done, divergence_err
    );
endinterface

// File: rtl/warp_scheduler.sv
// Per-core warp scheduler: runs FETCH/DECODE/REQUEST/WAIT/EXECUTE/UPDATE for
// NUM_WARPS warps sharing one pipeline. A warp whose LSUs are still busy in
// WAIT is parked and the next ready warp (round-robin) takes the pipeline with
// no idle cycle; a parked warp later resumes directly at EXECUTE.
//
// Ports
//   clk    clock
//   reset  synchronous, active-high
//   bus    warp_scheduler_if.master (see the interface file for signal list)
//
// Optional feature: define SCHED_DIVERGENCE_CHECK_EN to compare next_pc across
// the lanes in thread_mask during UPDATE (sticky divergence_err, pc from the
// lowest masked lane, mask of zero keeps pc). Without it pc takes the last
// lane and divergence_err is tied low.
module warp_scheduler #(
    parameter int NUM_WARPS        = 4,
    parameter int THREADS_PER_WARP = 4,
    parameter int PC_WIDTH         = 8
) (
    input  logic             clk,
    input  logic             reset,
    warp_scheduler_if.master bus
);
    localparam int WW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int TW = THREADS_PER_WARP;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_REQUEST, S_WAIT, S_EXECUTE, S_UPDATE, S_DONE
    } state_t;

    // The active warp keeps whatever ready status it was launched with; it is
    // excluded from every "other warp" query by index instead.
    typedef enum logic [2:0] {
        W_UNUSED, W_READY_F, W_PARKED, W_READY_X, W_FINISHED
    } wstat_t;

    state_t               state_reg, state_next;
    logic [WW-1:0]        aw_reg, aw_next;
    logic [WW-1:0]        rr_ptr_reg, rr_ptr_next;
    logic [PC_WIDTH-1:0]  pc_reg  [NUM_WARPS];
    logic [PC_WIDTH-1:0]  pc_next [NUM_WARPS];
    wstat_t               stat_reg  [NUM_WARPS];
    wstat_t               stat_eff  [NUM_WARPS];
    wstat_t               stat_next [NUM_WARPS];
    logic [NUM_WARPS-1:0] warp_done_reg, warp_done_next;
    logic                 block_done_reg, block_done_next;

    logic [NUM_WARPS-1:0] busy, ready_other, parked_other;
    logic                 sel_hit, do_select;
    logic [WW-1:0]        sel_idx, park_idx, first_en_idx;
    int                   scan_idx;
    logic [PC_WIDTH-1:0]  upd_pc;
    logic                 upd_load;

    // Per-warp LSU busy, PARKED->READY_X promotion (visible to this cycle's
    // decisions), and the "some other warp" masks.
    generate
        for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
            logic [TW-1:0] lane_busy;
            for (genvar gj = 0; gj < TW; gj++) begin : g_lane
                assign lane_busy[gj] = (bus.lsu_state[(gi*TW+gj)*2 +: 2] == 2'b01) ||
                                       (bus.lsu_state[(gi*TW+gj)*2 +: 2] == 2'b10);
            end
            assign busy[gi]         = |lane_busy;
            assign stat_eff[gi]     = (stat_reg[gi] == W_PARKED && !busy[gi]) ? W_READY_X : stat_reg[gi];
            assign ready_other[gi]  = (aw_reg != WW'(gi)) &&
                                      (stat_eff[gi] == W_READY_F || stat_eff[gi] == W_READY_X);
            assign parked_other[gi] = (aw_reg != WW'(gi)) && (stat_eff[gi] == W_PARKED);
        end
    endgenerate

    // Round-robin scan from rr_ptr+1; walking the offsets downwards leaves the
    // first hit in scan order as the final assignment.
    always_comb begin
        sel_hit      = 1'b0;
        sel_idx      = '0;
        scan_idx     = 0;
        park_idx     = '0;
        first_en_idx = '0;
        for (int k = NUM_WARPS; k >= 1; k--) begin
            scan_idx = (int'(rr_ptr_reg) + k) % NUM_WARPS;
            if (ready_other[WW'(scan_idx)]) begin
                sel_hit = 1'b1;
                sel_idx = WW'(scan_idx);
            end
        end
        for (int w = NUM_WARPS - 1; w >= 0; w--) begin
            if (parked_other[w])    park_idx     = WW'(w);
            if (bus.warp_enable[w]) first_en_idx = WW'(w);
        end
    end

`ifdef SCHED_DIVERGENCE_CHECK_EN
    logic upd_diverge;
    logic div_err_reg;

    always_comb begin
        upd_pc      = '0;
        upd_load    = |bus.thread_mask;
        upd_diverge = 1'b0;
        for (int t = TW - 1; t >= 0; t--) begin
            if (bus.thread_mask[t]) upd_pc = bus.next_pc[t*PC_WIDTH +: PC_WIDTH];
        end
        for (int t = 0; t < TW; t++) begin
            if (bus.thread_mask[t] && bus.next_pc[t*PC_WIDTH +: PC_WIDTH] != upd_pc) upd_diverge = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)                                  div_err_reg <= 1'b0;
        else if (state_reg == S_UPDATE && upd_diverge) div_err_reg <= 1'b1;
    end

    assign bus.divergence_err = div_err_reg;
`else
    logic unused_lane_inputs;
    assign unused_lane_inputs = ^{bus.thread_mask, bus.next_pc};
    assign upd_pc             = bus.next_pc[(TW-1)*PC_WIDTH +: PC_WIDTH];
    assign upd_load           = 1'b1;
    assign bus.divergence_err = 1'b0;
`endif

    always_comb begin
        state_next      = state_reg;
        aw_next         = aw_reg;
        rr_ptr_next     = rr_ptr_reg;
        warp_done_next  = warp_done_reg;
        block_done_next = block_done_reg;
        do_select       = 1'b0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            pc_next[w]   = pc_reg[w];
            stat_next[w] = stat_eff[w];
        end

        case (state_reg)
            S_IDLE: begin
                if (bus.start) begin
                    for (int w = 0; w < NUM_WARPS; w++) begin
                        pc_next[w]   = '0;
                        stat_next[w] = bus.warp_enable[w] ? W_READY_F : W_UNUSED;
                    end
                    if (bus.warp_enable == '0) begin
                        state_next      = S_DONE;
                        block_done_next = 1'b1;
                    end else begin
                        state_next = S_FETCH;
                        aw_next    = first_en_idx;
                    end
                end
            end
            S_FETCH:   if (bus.fetcher_state == 3'b010) state_next = S_DECODE;
            S_DECODE:  state_next = S_REQUEST;
            S_REQUEST: begin
                if (bus.decoded_ret) begin
                    warp_done_next[aw_reg] = 1'b1;
                    stat_next[aw_reg]      = W_FINISHED;
                    do_select              = 1'b1;
                end else begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!busy[aw_reg]) begin
                    state_next = S_EXECUTE;
                end else if (|ready_other) begin
                    stat_next[aw_reg] = W_PARKED;
                    do_select         = 1'b1;
                end
            end
            S_EXECUTE: state_next = S_UPDATE;
            S_UPDATE: begin
                if (upd_load) pc_next[aw_reg] = upd_pc;
                state_next = S_FETCH;
            end
            S_DONE: begin
                if (!bus.start) begin
                    state_next      = S_IDLE;
                    warp_done_next  = '0;
                    block_done_next = 1'b0;
                end
            end
            default: state_next = S_IDLE;
        endcase

        // Warp switch resolves on the same edge as the parking/RET decision.
        if (do_select) begin
            if (sel_hit) begin
                aw_next     = sel_idx;
                rr_ptr_next = sel_idx;
                state_next  = (stat_eff[sel_idx] == W_READY_X) ? S_EXECUTE : S_FETCH;
            end else if (|parked_other) begin
                // Nothing runnable: sit in WAIT on the lowest parked warp.
                aw_next             = park_idx;
                stat_next[park_idx] = W_READY_X;
                state_next          = S_WAIT;
            end else begin
                state_next      = S_DONE;
                block_done_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            aw_reg         <= '0;
            rr_ptr_reg     <= '0;
            warp_done_reg  <= '0;
            block_done_reg <= 1'b0;
            for (int w = 0; w < NUM_WARPS; w++) begin
                pc_reg[w]   <= '0;
                stat_reg[w] <= W_UNUSED;
            end
        end else begin
            state_reg      <= state_next;
            aw_reg         <= aw_next;
            rr_ptr_reg     <= rr_ptr_next;
            warp_done_reg  <= warp_done_next;
            block_done_reg <= block_done_next;
            for (int w = 0; w < NUM_WARPS; w++) begin
                pc_reg[w]   <= pc_next[w];
                stat_reg[w] <= stat_next[w];
            end
        end
    end

    assign bus.core_state  = state_reg;
    assign bus.active_warp = aw_reg;
    assign bus.current_pc  = pc_reg[aw_reg];
    assign bus.warp_done   = warp_done_reg;
    assign bus.block_done  = block_done_reg;
endmodule

// File: tb/tb_warp_scheduler.sv
// Testbench for warp_scheduler: directed literal scenarios followed by a long
// randomized run, all checked every cycle against a queue-based warp model.
module tb_warp_scheduler;
    localparam int NW = 4;
    localparam int NT = 4;
    localparam int PW = 8;
    localparam int ST_UNUSED = 0, ST_RF = 1, ST_PARK = 2, ST_RX = 3, ST_FIN = 4, ST_RUN = 5;
`ifdef SCHED_DIVERGENCE_CHECK_EN
    localparam int EXP_ERR = 1;
`else
    localparam int EXP_ERR = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    warp_scheduler_if #(.NUM_WARPS(NW), .THREADS_PER_WARP(NT), .PC_WIDTH(PW)) sif ();

    warp_scheduler #(.NUM_WARPS(NW), .THREADS_PER_WARP(NT), .PC_WIDTH(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Reference model state
    int            m_state, m_aw, m_rr;
    int            m_stat [NW];
    logic [PW-1:0] m_pc   [NW];
    logic [NW-1:0] m_done;
    logic          m_block, m_err;
    int            lsu_cnt [NW*NT];
    int            seq1 [7] = '{1, 2, 3, 4, 5, 6, 1};

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit warp_busy(input int w);
        bit b = 1'b0;
        for (int t = 0; t < NT; t++) begin
            logic [1:0] s;
            s = sif.lsu_state[(w*NT+t)*2 +: 2];
            if (s == 2'b01 || s == 2'b10) b = 1'b1;
        end
        return b;
    endfunction

    task automatic model_select();
        int q[$];
        int parked[$];
        for (int k = 1; k <= NW; k++) begin
            int w;
            w = (m_rr + k) % NW;
            if (m_stat[w] == ST_RF || m_stat[w] == ST_RX) q.push_back(w);
        end
        for (int w = 0; w < NW; w++) if (m_stat[w] == ST_PARK) parked.push_back(w);
        if (q.size() > 0) begin
            m_aw = q[0];
            m_rr = q[0];
            m_state = (m_stat[q[0]] == ST_RX) ? 5 : 1;
            m_stat[q[0]] = ST_RUN;
        end else if (parked.size() > 0) begin
            m_aw = parked[0];
            m_stat[m_aw] = ST_RUN;
            m_state = 4;
        end else begin
            m_state = 7;
            m_block = 1'b1;
        end
    endtask

    task automatic model_step();
        bit any_ready;
`ifdef SCHED_DIVERGENCE_CHECK_EN
        logic [PW-1:0] vals[$];
`endif
        if (reset) begin
            m_state = 0; m_aw = 0; m_rr = 0;
            m_done = '0; m_block = 1'b0; m_err = 1'b0;
            for (int w = 0; w < NW; w++) begin
                m_pc[w] = '0;
                m_stat[w] = ST_UNUSED;
            end
            return;
        end
        for (int w = 0; w < NW; w++)
            if (m_stat[w] == ST_PARK && !warp_busy(w)) m_stat[w] = ST_RX;
        case (m_state)
            0: if (sif.start) begin
                for (int w = 0; w < NW; w++) begin
                    m_pc[w] = '0;
                    m_stat[w] = sif.warp_enable[w] ? ST_RF : ST_UNUSED;
                end
                if (sif.warp_enable == '0) begin
                    m_state = 7;
                    m_block = 1'b1;
                end else begin
                    for (int w = NW - 1; w >= 0; w--) if (sif.warp_enable[w]) m_aw = w;
                    m_stat[m_aw] = ST_RUN;
                    m_state = 1;
                end
            end
            1: if (sif.fetcher_state == 3'b010) m_state = 2;
            2: m_state = 3;
            3: if (sif.decoded_ret) begin
                m_done[m_aw] = 1'b1;
                m_stat[m_aw] = ST_FIN;
                model_select();
            end else begin
                m_state = 4;
            end
            4: begin
                any_ready = 1'b0;
                for (int w = 0; w < NW; w++)
                    if (m_stat[w] == ST_RF || m_stat[w] == ST_RX) any_ready = 1'b1;
                if (!warp_busy(m_aw)) m_state = 5;
                else if (any_ready) begin
                    m_stat[m_aw] = ST_PARK;
                    model_select();
                end
            end
            5: m_state = 6;
            6: begin
`ifdef SCHED_DIVERGENCE_CHECK_EN
                for (int t = 0; t < NT; t++)
                    if (sif.thread_mask[t]) vals.push_back(sif.next_pc[t*PW +: PW]);
                if (vals.size() > 0) begin
                    m_pc[m_aw] = vals[0];
                    foreach (vals[i]) if (vals[i] != vals[0]) m_err = 1'b1;
                end
`else
                m_pc[m_aw] = sif.next_pc[(NT-1)*PW +: PW];
`endif
                m_state = 1;
            end
            default: if (!sif.start) begin
                m_state = 0;
                m_done = '0;
                m_block = 1'b0;
            end
        endcase
    endtask

    // One clock: model consumes the inputs at the edge, control returns mid-cycle.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // Compare process: DUT outputs vs model, every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("core_state", int'(sif.core_state), m_state);
            chk("active_warp", int'(sif.active_warp), m_aw);
            chk("current_pc", int'(sif.current_pc), int'(m_pc[m_aw]));
            chk("warp_done", int'(sif.warp_done), int'(m_done));
            chk("block_done", int'(sif.block_done), int'(m_block));
            chk("divergence_err", int'(sif.divergence_err), int'(m_err));
        end
    end

    task automatic lit(input string tag, input int st, input int aw, input int pc, input int dn, input int bd);
        chk({tag, "_state"}, int'(sif.core_state), st);
        chk({tag, "_aw"}, int'(sif.active_warp), aw);
        chk({tag, "_pc"}, int'(sif.current_pc), pc);
        chk({tag, "_done"}, int'(sif.warp_done), dn);
        chk({tag, "_block"}, int'(sif.block_done), bd);
    endtask

    task automatic lit_sa(input string tag, input int st, input int aw);
        chk({tag, "_state"}, int'(sif.core_state), st);
        chk({tag, "_aw"}, int'(sif.active_warp), aw);
    endtask

    task automatic drive_random();
        logic [NW*NT*2-1:0] l;
        logic [NT*PW-1:0]   np;
        logic [PW-1:0]      v;
        for (int i = 0; i < NW*NT; i++) begin
            if (lsu_cnt[i] > 0) lsu_cnt[i]--;
            else if ($urandom_range(0, 9) == 0) lsu_cnt[i] = int'($urandom_range(1, 12));
            if (lsu_cnt[i] > 0) l[i*2 +: 2] = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
            else                l[i*2 +: 2] = ($urandom_range(0, 1) == 1) ? 2'b00 : 2'b11;
        end
        sif.lsu_state = l;
        v = PW'($urandom);
        for (int t = 0; t < NT; t++)
            np[t*PW +: PW] = ($urandom_range(0, 1) == 1) ? v : PW'($urandom);
        sif.next_pc       = np;
        sif.thread_mask   = ($urandom_range(0, 3) == 0) ? 4'hF : NT'($urandom);
        sif.fetcher_state = ($urandom_range(0, 2) == 0) ? 3'b010 : 3'($urandom_range(0, 7));
        sif.decoded_ret   = ($urandom_range(0, 7) == 0);
        if (m_state == 7 && $urandom_range(0, 2) == 0) sif.start = 1'b0;
        else if (m_state == 0 && $urandom_range(0, 1) == 0) sif.start = 1'b1;
        if (m_state == 0) sif.warp_enable = NW'($urandom);
        reset = ($urandom_range(0, 399) == 0);
    endtask

    initial begin
        reset = 1'b1;
        sif.start = 1'b0;
        sif.warp_enable = '0;
        sif.fetcher_state = '0;
        sif.decoded_ret = 1'b0;
        sif.lsu_state = '0;
        sif.thread_mask = '0;
        sif.next_pc = '0;
        for (int i = 0; i < NW*NT; i++) lsu_cnt[i] = 0;
        @(negedge clk);
        cycle();
        cycle();
        chk_en = 1'b1;
        lit("rst", 0, 0, 0, 0, 0);
        chk("rst_err", int'(sif.divergence_err), 0);
        reset = 1'b0;

        // Launch with no enabled warps
        sif.start = 1'b1;
        cycle();
        lit("empty", 7, 0, 0, 0, 1);
        sif.start = 1'b0;
        cycle();
        lit("empty_idle", 0, 0, 0, 0, 0);

        // Single warp: full pass, then RET
        sif.warp_enable = 4'b0001;
        sif.start = 1'b1;
        sif.fetcher_state = 3'b010;
        sif.thread_mask = 4'hF;
        sif.next_pc = {8'd9, 8'd9, 8'd7, 8'd9};
        for (int i = 0; i < 7; i++) begin
            cycle();
            chk("seq_state", int'(sif.core_state), seq1[i]);
        end
        chk("upd_pc", int'(sif.current_pc), 9);
        chk("upd_err", int'(sif.divergence_err), EXP_ERR);
        sif.decoded_ret = 1'b1;
        cycle();
        cycle();
        cycle();
        lit("ret", 7, 0, 9, 1, 1);
        sif.start = 1'b0;
        sif.decoded_ret = 1'b0;
        cycle();
        lit("ret_idle", 0, 0, 9, 0, 0);

        // Two warps: w0 busy in WAIT parks, w1 switched in; then reset in WAIT
        sif.warp_enable = 4'b0011;
        sif.start = 1'b1;
        sif.lsu_state = 32'h0000_0055;
        cycle();
        lit_sa("p_fetch", 1, 0);
        cycle();
        cycle();
        cycle();
        lit_sa("p_wait", 4, 0);
        cycle();
        lit_sa("p_switch", 1, 1);
        sif.lsu_state = 32'h5555_5555;
        cycle();
        cycle();
        cycle();
        lit_sa("p_wait1", 4, 1);
        cycle();
        lit_sa("p_hold", 4, 1);
        reset = 1'b1;
        cycle();
        lit("midrst", 0, 0, 0, 0, 0);
        chk("midrst_err", int'(sif.divergence_err), 0);
        reset = 1'b0;

        // Randomized run against the model
        for (int c = 0; c < 4000; c++) begin
            drive_random();
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
